rram_access_sequencer: RTL and testbench

Host-side request sequencer that sits directly upstream of controller_5V in the RRAM macro. It accepts read/write requests over a valid/ready handshake into a 2-entry request FIFO. For each request it issues a single-cycle EN pulse with stable RW/X/Y to the controller, then holds write data for the duration of the operation. On reads it captures the sense-amplifier word while EN_SA is high and returns one response per operation.

---
 rtl/rram_access_sequencer.sv | 146 ++++++++++++++
 tb/tb_rram_access_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rram_access_sequencer.sv
// rram_access_sequencer: 2-deep request FIFO that issues EN pulses to controller_5V and returns one response per op
module rram_access_sequencer #(
  parameter int B_SIZE    = 4,
  parameter int X_SIZE    = 4,
  parameter int Y_SIZE    = 6,
  parameter int RD_CYCLES = 4,
  parameter int WR_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic                     REQ_RW,
  input  logic [X_SIZE+Y_SIZE-1:0] REQ_ADDR,
  input  logic [B_SIZE-1:0]        REQ_WDATA,
  output logic                     EN,
  output logic                     RW,
  output logic [X_SIZE-1:0]        X_ADDRESS_IN,
  output logic [Y_SIZE-1:0]        Y_ADDRESS_IN,
  output logic [B_SIZE-1:0]        WDATA,
  input  logic                     EN_SA,
  input  logic [B_SIZE-1:0]        SA_DATA,
  output logic                     RSP_VALID,
  output logic                     RSP_RW,
  output logic [B_SIZE-1:0]        RSP_RDATA,
  output logic                     RSP_ERR,
  output logic                     BUSY
);
  localparam int E_SIZE = 1 + X_SIZE + Y_SIZE + B_SIZE;
  localparam int C_SIZE = $clog2((RD_CYCLES > WR_CYCLES ? RD_CYCLES : WR_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD, RESP} state_t;
  state_t r_state, w_state_nxt;
  logic [E_SIZE-1:0] r_mem [2];
  logic              r_wp, r_rp;
  logic [1:0]        r_count, w_count_nxt;
  logic              w_push, w_pop;
  logic [E_SIZE-1:0] w_head;
  logic [C_SIZE-1:0] r_cnt, w_cnt_nxt;
  logic              r_en, w_en_nxt, r_rw, w_rw_nxt;
  logic [X_SIZE-1:0] r_x, w_x_nxt;
  logic [Y_SIZE-1:0] r_y, w_y_nxt;
  logic [B_SIZE-1:0] r_wdata, w_wdata_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt, r_rsp_rw, w_rsp_rw_nxt;
  logic [B_SIZE-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_ready, r_busy;
  assign REQ_READY    = r_ready;
  assign EN           = r_en;
  assign RW           = r_rw;
  assign X_ADDRESS_IN = r_x;
  assign Y_ADDRESS_IN = r_y;
  assign WDATA        = r_wdata;
  assign RSP_VALID    = r_rsp_valid;
  assign RSP_RW       = r_rsp_rw;
  assign RSP_RDATA    = r_rsp_rdata;
  assign RSP_ERR      = r_rsp_err;
  assign BUSY         = r_busy;
  always_comb begin
    w_push          = REQ_VALID && r_ready;
    w_pop           = (r_state == IDLE) && (r_count != 2'd0);
    w_head          = r_mem[r_rp];
    w_count_nxt     = r_count + {1'b0, w_push} - {1'b0, w_pop};
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_en_nxt        = 1'b0;
    w_rw_nxt        = r_rw;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_wdata_nxt     = r_wdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rw_nxt    = r_rsp_rw;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      IDLE: if (w_pop) begin
        w_state_nxt = ISSUE;
        w_en_nxt    = 1'b1;
        {w_rw_nxt, w_y_nxt, w_x_nxt, w_wdata_nxt} = w_head;
      end
      ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = r_rw ? WAIT_RD : WAIT_WR;
      end
      WAIT_WR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == C_SIZE'(WR_CYCLES - 1)) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rw_nxt    = 1'b0;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b0;
        end
      end
      WAIT_RD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (EN_SA || r_cnt == C_SIZE'(RD_CYCLES - 1)) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rw_nxt    = 1'b1;
          w_rsp_rdata_nxt = EN_SA ? SA_DATA : '0;
          w_rsp_err_nxt   = !EN_SA;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= '0;
      r_en        <= 1'b0;
      r_rw        <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rw    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      if (w_push) r_mem[r_wp] <= {REQ_RW, REQ_ADDR, REQ_WDATA};
      r_wp        <= r_wp ^ w_push;
      r_rp        <= r_rp ^ w_pop;
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_cnt       <= w_cnt_nxt;
      r_en        <= w_en_nxt;
      r_rw        <= w_rw_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rw    <= w_rsp_rw_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_ready     <= w_count_nxt != 2'd2;
      r_busy      <= (w_state_nxt != IDLE) || (w_count_nxt != 2'd0);
    end
  end
endmodule

// File: tb/tb_rram_access_sequencer.sv
// tb_rram_access_sequencer: scoreboard bench with a small controller model driving EN_SA per request
module tb_rram_access_sequencer;
  localparam int B = 4, X = 4, Y = 6, RD = 4, WR = 2;
  logic clk = 0, reset = 1, REQ_VALID = 0, REQ_RW = 0, EN_SA = 0;
  logic [X+Y-1:0] REQ_ADDR = '0;
  logic [B-1:0] REQ_WDATA = '0, SA_DATA = '0;
  logic REQ_READY, EN, RW, RSP_VALID, RSP_RW, RSP_ERR, BUSY;
  logic [X-1:0] X_ADDRESS_IN;
  logic [Y-1:0] Y_ADDRESS_IN;
  logic [B-1:0] WDATA, RSP_RDATA;
  rram_access_sequencer #(.B_SIZE(B), .X_SIZE(X), .Y_SIZE(Y), .RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
    .clk(clk), .reset(reset), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_RW(REQ_RW),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .EN(EN), .RW(RW), .X_ADDRESS_IN(X_ADDRESS_IN),
    .Y_ADDRESS_IN(Y_ADDRESS_IN), .WDATA(WDATA), .EN_SA(EN_SA), .SA_DATA(SA_DATA),
    .RSP_VALID(RSP_VALID), .RSP_RW(RSP_RW), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
  );
  always #5 clk = ~clk;
  typedef struct {logic rw; logic [X-1:0] x; logic [Y-1:0] y; logic [B-1:0] wd; int d; logic [B-1:0] sd; int en_lat;} op_t;
  typedef struct {logic rw; logic [B-1:0] rdata; logic err; int lat;} rsp_t;
  op_t  q_op[$];
  rsp_t q_rsp[$];
  op_t  cur;
  bit   active, sa_force;
  int   cyc, last_en, acc_cyc, n_chk, n_pass;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask
  task automatic monitor();
    rsp_t r;
    if (active && cyc != last_en) begin
      check("hold_rw", RW, cur.rw);
      check("hold_x", X_ADDRESS_IN, cur.x);
      check("hold_y", Y_ADDRESS_IN, cur.y);
      check("hold_wdata", WDATA, cur.wd);
    end
    if (EN === 1'b1) begin
      if (active || q_op.size() == 0) check("en_unexpected", EN, 1'b0);
      else begin
        cur = q_op.pop_front();
        active = 1;
        last_en = cyc;
        check("en_rw", RW, cur.rw);
        check("en_x", X_ADDRESS_IN, cur.x);
        check("en_y", Y_ADDRESS_IN, cur.y);
        check("en_wdata", WDATA, cur.wd);
        if (cur.en_lat >= 0) check("en_latency", cyc - acc_cyc, cur.en_lat);
      end
    end
    if (RSP_VALID === 1'b1) begin
      if (q_rsp.size() == 0) check("rsp_unexpected", RSP_VALID, 1'b0);
      else begin
        r = q_rsp.pop_front();
        check("rsp_rw", RSP_RW, r.rw);
        check("rsp_rdata", RSP_RDATA, r.rdata);
        check("rsp_err", RSP_ERR, r.err);
        check("rsp_latency", cyc - last_en, r.lat);
        active = 0;
      end
    end
    EN_SA = sa_force || (active && cur.rw && cur.d > 0 && cyc == last_en + cur.d);
    SA_DATA = sa_force ? 4'hF : (active ? cur.sd : 4'h0);
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    monitor();
  endtask
  task automatic send(logic rw, logic [X-1:0] x, logic [Y-1:0] y, logic [B-1:0] wd, int d, logic [B-1:0] sd, int en_lat);
    op_t o;
    rsp_t r;
    int n = 0;
    o = '{rw, x, y, wd, d, sd, en_lat};
    r.rw = rw;
    r.err = rw && !(d >= 1 && d <= RD);
    r.rdata = (rw && !r.err) ? sd : '0;
    r.lat = !rw ? 1 + WR : (r.err ? 1 + RD : d + 1);
    REQ_VALID = 1; REQ_RW = rw; REQ_ADDR = {y, x}; REQ_WDATA = wd;
    while (!REQ_READY && n < 50) begin step(); n++; end
    if (!REQ_READY) check("ready_timeout", REQ_READY, 1'b1);
    q_op.push_back(o);
    q_rsp.push_back(r);
    step();
    acc_cyc = cyc;
    REQ_VALID = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q_rsp.size() != 0 && n < 200) begin step(); n++; end
    check("drain", q_rsp.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) step();
    check("rst_en", EN, 0);
    check("rst_rw", RW, 0);
    check("rst_x", X_ADDRESS_IN, 0);
    check("rst_y", Y_ADDRESS_IN, 0);
    check("rst_wdata", WDATA, 0);
    check("rst_rsp_valid", RSP_VALID, 0);
    check("rst_rsp_rdata", RSP_RDATA, 0);
    check("rst_rsp_err", RSP_ERR, 0);
    check("rst_busy", BUSY, 0);
    check("rst_ready", REQ_READY, 1);
    reset = 0;
    step();
    send(0, 4'd2, 6'd4, 4'hA, 0, 4'h0, 1);
    drain(); step();
    send(1, 4'd15, 6'd63, 4'h0, 3, 4'h5, 1);
    drain(); step();
    send(1, 4'd3, 6'd7, 4'h0, 0, 4'h9, 1);
    drain(); step();
    send(1, 4'd1, 6'd1, 4'h0, 4, 4'hC, 1);
    drain(); step();
    send(0, 4'd5, 6'd9, 4'h3, 0, 4'h0, 1);
    send(1, 4'd6, 6'd10, 4'h0, 2, 4'h7, -1);
    send(0, 4'd7, 6'd11, 4'hE, 0, 4'h0, -1);
    check("ready_full", REQ_READY, 0);
    check("busy_full", BUSY, 1);
    drain(); step(); step();
    check("idle_busy", BUSY, 0);
    check("idle_ready", REQ_READY, 1);
    sa_force = 1;
    repeat (3) step();
    sa_force = 0;
    step();
    check("idle_sa_rdata", RSP_RDATA, 4'h0);
    send(0, 4'd8, 6'd12, 4'h5, 0, 4'h0, 1);
    sa_force = 1;
    drain();
    sa_force = 0;
    step();
    send(1, 4'd2, 6'd3, 4'h0, 0, 4'h1, 1);
    send(0, 4'd4, 6'd5, 4'h6, 0, 4'h0, -1);
    step(); step();
    reset = 1;
    q_op.delete();
    q_rsp.delete();
    active = 0;
    step();
    check("abort_en", EN, 0);
    check("abort_rsp_valid", RSP_VALID, 0);
    check("abort_busy", BUSY, 0);
    check("abort_ready", REQ_READY, 1);
    reset = 0;
    repeat (20) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
